// File: rtl/button_scan_ctrl.sv
// Multi-button synchronizer/debouncer with round-robin valid/ready press-event delivery.
// Optional release events: define BUTTON_SCAN_RELEASE_EVT_EN.
module button_scan_ctrl #(
   parameter int unsigned NUM_BTNS      = 4,
   parameter int unsigned DEBOUNCE_WAIT = 8,
   parameter int unsigned TICK_DIV      = 1,
   localparam int unsigned ID_W = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_BTNS-1:0] btn_in,
   output logic [NUM_BTNS-1:0] btn_state,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [ID_W-1:0]     evt_id,
`ifdef BUTTON_SCAN_RELEASE_EVT_EN
   output logic                evt_release,
`endif
   output logic                evt_overflow
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_WAIT) + 1;
   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_WAIT - 1);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   typedef enum logic {IDLE, OFFER} state_t;

   state_t              state;
   logic [NUM_BTNS-1:0] sync1, sync2;
   logic [PRE_W-1:0]    pre_cnt;
   logic                tick_c;
   logic [NUM_BTNS-1:0] rise_c;
   logic [ID_W-1:0]     ptr;
   logic [NUM_BTNS-1:0] pending;
   logic [NUM_BTNS-1:0] pending_nxt_c;
   logic [NUM_BTNS-1:0] elig_c;
   logic [NUM_BTNS-1:0] sel_mask_c;
   logic [NUM_BTNS-1:0] clr_press_c;
   logic                accept_c;
   logic                ovf_c;
   logic                ptr_adv_c;
   logic                sel_found_c;
   logic [ID_W-1:0]     sel_idx_c;
   logic [ID_W-1:0]     cand_c;

   // Input synchronizer and shared sample-tick prescaler
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         pre_cnt <= '0;
      end else begin
         sync1   <= btn_in;
         sync2   <= sync1;
         pre_cnt <= (pre_cnt == PRE_MAX) ? '0 : pre_cnt + 1'b1;
      end
   end

   assign tick_c = (pre_cnt == PRE_MAX);

`ifdef BUTTON_SCAN_RELEASE_EVT_EN
   logic [NUM_BTNS-1:0] fall_c;
`endif

   for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
      logic [CNT_W-1:0] cnt;
      logic             state_q;
      logic             flip_c;

      assign flip_c = tick_c && (sync2[i] != state_q) && (cnt == CNT_MAX);

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            cnt     <= '0;
            state_q <= 1'b0;
         end else if (tick_c) begin
            if (sync2[i] == state_q) begin
               cnt <= '0;
            end else if (cnt == CNT_MAX) begin
               state_q <= ~state_q;
               cnt     <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end

      assign btn_state[i] = state_q;
      assign rise_c[i]    = flip_c & ~state_q;
`ifdef BUTTON_SCAN_RELEASE_EVT_EN
      assign fall_c[i]    = flip_c & state_q;
`endif
   end

   assign accept_c   = (state == OFFER) && evt_ready;
   assign sel_mask_c = NUM_BTNS'(1) << evt_id;

`ifdef BUTTON_SCAN_RELEASE_EVT_EN
   logic [NUM_BTNS-1:0] rel_pending;
   logic [NUM_BTNS-1:0] rel_nxt_c;
   logic [NUM_BTNS-1:0] clr_rel_c;

   assign clr_press_c   = (accept_c && !evt_release) ? sel_mask_c : '0;
   assign clr_rel_c     = (accept_c &&  evt_release) ? sel_mask_c : '0;
   assign elig_c        = pending | rel_pending;
   assign pending_nxt_c = (pending & ~clr_press_c) | rise_c;
   assign rel_nxt_c     = (rel_pending & ~clr_rel_c) | fall_c;
   assign ovf_c         = (|(rise_c & pending & ~clr_press_c)) |
                          (|(fall_c & rel_pending & ~clr_rel_c));
   // Pointer moves past a button only once all of its flags are delivered
   assign ptr_adv_c     = evt_release ? !pending[evt_id] : !rel_pending[evt_id];
`else
   assign clr_press_c   = accept_c ? sel_mask_c : '0;
   assign elig_c        = pending;
   assign pending_nxt_c = (pending & ~clr_press_c) | rise_c;
   assign ovf_c         = |(rise_c & pending & ~clr_press_c);
   assign ptr_adv_c     = 1'b1;
`endif

   // Round-robin search starting one past the last granted button
   always_comb begin
      sel_found_c = 1'b0;
      sel_idx_c   = '0;
      cand_c      = '0;
      for (int unsigned k = 1; k <= NUM_BTNS; k++) begin
         cand_c = ID_W'((32'(ptr) + k) % NUM_BTNS);
         if (!sel_found_c && elig_c[cand_c]) begin
            sel_found_c = 1'b1;
            sel_idx_c   = cand_c;
         end
      end
   end

   // Event arbiter FSM and pending flags
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         evt_valid    <= 1'b0;
         evt_id       <= '0;
         evt_overflow <= 1'b0;
         pending      <= '0;
         ptr          <= ID_W'(NUM_BTNS - 1);
`ifdef BUTTON_SCAN_RELEASE_EVT_EN
         rel_pending  <= '0;
         evt_release  <= 1'b0;
`endif
      end else begin
         pending      <= pending_nxt_c;
         evt_overflow <= ovf_c;
`ifdef BUTTON_SCAN_RELEASE_EVT_EN
         rel_pending  <= rel_nxt_c;
`endif
         case (state)
            IDLE: begin
               if (sel_found_c) begin
                  evt_id    <= sel_idx_c;
                  evt_valid <= 1'b1;
                  state     <= OFFER;
`ifdef BUTTON_SCAN_RELEASE_EVT_EN
                  evt_release <= !pending[sel_idx_c];
`endif
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  evt_valid <= 1'b0;
                  state     <= IDLE;
                  if (ptr_adv_c) ptr <= evt_id;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_button_scan_ctrl.sv
// Directed self-checking bench for button_scan_ctrl (default build).
module tb_button_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, rst2_n;
   logic [3:0] btn_in, btn2;
   logic [3:0] btn_state, btn_state2;
   logic       evt_valid, evt_valid2;
   logic       evt_ready, evt_ready2;
   logic [1:0] evt_id, evt_id2;
   logic       evt_overflow, evt_overflow2;

   int checks   = 0;
   int failures = 0;
   int valid_cycles, ovf_cycles, cyc, v2_cycles;
   int ids[$];
   int cycs[$];

   always #5 clk = ~clk;

   button_scan_ctrl #(.NUM_BTNS(4), .DEBOUNCE_WAIT(8), .TICK_DIV(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .btn_state(btn_state),
      .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_id(evt_id),
      .evt_overflow(evt_overflow)
   );

   button_scan_ctrl #(.NUM_BTNS(4), .DEBOUNCE_WAIT(2), .TICK_DIV(4)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .btn_in(btn2), .btn_state(btn_state2),
      .evt_valid(evt_valid2), .evt_ready(evt_ready2), .evt_id(evt_id2),
      .evt_overflow(evt_overflow2)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stats();
      valid_cycles = 0;
      ovf_cycles   = 0;
      cyc          = 0;
      ids.delete();
      cycs.delete();
   endtask

   // Handshakes are recorded just before the edge that completes them
   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         if (evt_valid && evt_ready) begin
            ids.push_back(int'(evt_id));
            cycs.push_back(cyc);
         end
         tick();
         cyc++;
         if (evt_valid)    valid_cycles++;
         if (evt_overflow) ovf_cycles++;
      end
   endtask

   initial begin
      rst_n = 1'b0; btn_in = 4'hF; evt_ready = 1'b0;
      rst2_n = 1'b0; btn2 = 4'h0; evt_ready2 = 1'b0;

      // Reset with all buttons held
      repeat (3) tick();
      chk("rst_btn_state", int'(btn_state), 0);
      chk("rst_evt_valid", int'(evt_valid), 0);
      chk("rst_evt_ovf", int'(evt_overflow), 0);
      rst_n = 1'b1;
      repeat (9) tick();
      chk("lat_state_edge9", int'(btn_state), 0);
      tick();
      chk("lat_state_edge10", int'(btn_state), 15);
      chk("lat_valid_edge10", int'(evt_valid), 0);
      tick();
      chk("lat_valid_edge11", int'(evt_valid), 1);
      chk("lat_id_edge11", int'(evt_id), 0);

      // Drain the four simultaneous presses
      evt_ready = 1'b1;
      clear_stats();
      watch(8);
      chk("drain_count", ids.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < ids.size()) chk("drain_id", ids[i], i);
      chk("drain_idle", int'(evt_valid), 0);

      // Releases produce no events
      clear_stats();
      btn_in = 4'h0;
      watch(14);
      chk("release_state", int'(btn_state), 0);
      chk("release_no_evt", valid_cycles, 0);

      // Bounce on button 1 never settles long enough
      evt_ready = 1'b0;
      clear_stats();
      for (int r = 0; r < 3; r++) begin
         btn_in = 4'h2; watch(4);
         btn_in = 4'h0; watch(4);
      end
      watch(12);
      chk("bounce_state", int'(btn_state), 0);
      chk("bounce_no_evt", valid_cycles, 0);

      // Single press on button 2
      evt_ready = 1'b1;
      clear_stats();
      btn_in = 4'h4;
      watch(16);
      chk("single_valid_cycles", valid_cycles, 1);
      chk("single_count", ids.size(), 1);
      if (ids.size() > 0) chk("single_id", ids[0], 2);
      chk("single_state", int'(btn_state), 4);
      chk("single_idle", int'(evt_valid), 0);

      // Round robin from reset: 0,1,3 on the same edge, spaced 2 clocks
      rst_n = 1'b0; btn_in = 4'h0;
      watch(2);
      rst_n = 1'b1;
      clear_stats();
      btn_in = 4'hB;
      watch(18);
      chk("rr_count", ids.size(), 3);
      if (ids.size() == 3) begin
         chk("rr_id0", ids[0], 0);
         chk("rr_id1", ids[1], 1);
         chk("rr_id2", ids[2], 3);
         chk("rr_gap01", cycs[1] - cycs[0], 2);
         chk("rr_gap12", cycs[2] - cycs[1], 2);
      end
      chk("rr_state", int'(btn_state), 11);

      clear_stats();
      btn_in = 4'h0;
      watch(14);
      chk("rr_release_no_evt", valid_cycles, 0);

      // Grant button 1 so the pointer sits at 1, then press 0 and 3 together
      clear_stats();
      btn_in = 4'h2;
      watch(14);
      chk("rr_b1_count", ids.size(), 1);
      if (ids.size() > 0) chk("rr_b1_id", ids[0], 1);
      clear_stats();
      btn_in = 4'hB;
      watch(16);
      chk("rr2_count", ids.size(), 2);
      if (ids.size() == 2) begin
         chk("rr2_id0", ids[0], 3);
         chk("rr2_id1", ids[1], 0);
      end

      // Overflow: press/release/press button 0 with no consumer
      evt_ready = 1'b0;
      btn_in = 4'h0;
      watch(14);
      clear_stats();
      btn_in = 4'h1; watch(14);
      chk("ovf_first_press", ovf_cycles, 0);
      chk("ovf_offer_id", int'(evt_id), 0);
      btn_in = 4'h0; watch(14);
      chk("ovf_after_release", ovf_cycles, 0);
      btn_in = 4'h1; watch(14);
      chk("ovf_pulse_cycles", ovf_cycles, 1);
      chk("ovf_valid_held", int'(evt_valid), 1);
      chk("ovf_id_held", int'(evt_id), 0);
      evt_ready = 1'b1;
      clear_stats();
      watch(8);
      chk("ovf_single_evt", ids.size(), 1);
      if (ids.size() > 0) chk("ovf_evt_id", ids[0], 0);
      chk("ovf_idle", int'(evt_valid), 0);

      // Prescaled instance: ticks land on edges 4, 8, ... after reset release
      rst2_n = 1'b1;
      btn2   = 4'h1;
      repeat (7) tick();
      chk("div_state_edge7", int'(btn_state2), 0);
      tick();
      chk("div_state_edge8", int'(btn_state2), 1);
      tick();
      chk("div_valid_edge9", int'(evt_valid2), 1);
      chk("div_id_edge9", int'(evt_id2), 0);
      rst2_n = 1'b0;
      btn2   = 4'h0;
      tick();
      chk("div_rst_valid", int'(evt_valid2), 0);
      chk("div_rst_state", int'(btn_state2), 0);
      rst2_n     = 1'b1;
      evt_ready2 = 1'b1;
      v2_cycles  = 0;
      for (int i = 0; i < 24; i++) begin
         tick();
         if (evt_valid2) v2_cycles++;
      end
      chk("div_no_stale_evt", v2_cycles, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
